// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the CPU pipeline and hazard_ctrl.
// master = pipeline side (drives hazard terms), slave = hazard_ctrl.
interface hazard_ctrl_if;
    logic [0:4]  ID_rA;
    logic [0:4]  ID_rB;
    logic        ID_rA_used;
    logic        ID_rB_used;
    logic        ID_is_branch;
    logic        ID_br_ctrl;
    logic [0:4]  EX_rD;
    logic        EX_wrEn;
    logic        EX_memEn;
    logic        EX_memwrEn;
    logic        dmem_req;
    logic        dmem_ack;
    logic        PC_wrEn;
    logic        IF_ID_wrEn;
    logic        IF_flush;
    logic        ID_EX_bubble;
    logic        pipe_hold;
    logic        mem_err;
    logic [0:15] stall_cnt;
    logic [0:15] flush_cnt;

    modport master (
        output ID_rA, ID_rB, ID_rA_used, ID_rB_used, ID_is_branch, ID_br_ctrl,
        output EX_rD, EX_wrEn, EX_memEn, EX_memwrEn, dmem_req, dmem_ack,
        input  PC_wrEn, IF_ID_wrEn, IF_flush, ID_EX_bubble, pipe_hold, mem_err,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  ID_rA, ID_rB, ID_rA_used, ID_rB_used, ID_is_branch, ID_br_ctrl,
        input  EX_rD, EX_wrEn, EX_memEn, EX_memwrEn, dmem_req, dmem_ack,
        output PC_wrEn, IF_ID_wrEn, IF_flush, ID_EX_bubble, pipe_hold, mem_err,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall sequencer: load-use, branch-operand, flush and dmem-wait control.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int LU_BUBBLES  = 2,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;

    localparam logic [1:0] LU_INIT    = 2'(LU_BUBBLES - 1);
    localparam logic [7:0] TIMER_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_reg, state_next;
    logic [1:0] bub_reg, bub_next;
    logic [7:0] timer_reg, timer_next;
    logic       mem_err_reg, mem_err_next;
    logic       drop_reg, drop_next;

    logic load_in_ex, a_hit, b_hit, load_use, br_dep, mem_stall;
    logic pc_wr, ifid_wr, flush, bubble, hold;

    assign load_in_ex = hz.EX_memEn & ~hz.EX_memwrEn & hz.EX_wrEn;
    assign a_hit      = hz.ID_rA_used & (hz.EX_rD == hz.ID_rA) & (hz.EX_rD != 5'd0);
    assign b_hit      = hz.ID_rB_used & (hz.EX_rD == hz.ID_rB) & (hz.EX_rD != 5'd0);
    assign load_use   = load_in_ex & (a_hit | b_hit);
    assign br_dep     = hz.ID_is_branch & hz.EX_wrEn & ~load_in_ex & b_hit;
    // A timed-out request stays masked until the MEM stage lets go of dmem_req.
    assign mem_stall  = hz.dmem_req & ~drop_reg & ~hz.dmem_ack;

    always_comb begin
        state_next   = state_reg;
        bub_next     = bub_reg;
        timer_next   = timer_reg;
        mem_err_next = mem_err_reg;
        drop_next    = drop_reg & hz.dmem_req;
        pc_wr        = 1'b1;
        ifid_wr      = 1'b1;
        flush        = 1'b0;
        bubble       = 1'b0;
        hold         = 1'b0;
        case (state_reg)
            RUN: begin
                if (mem_stall) begin
                    state_next = MEM_WAIT;
                    timer_next = 8'd0;
                    bub_next   = 2'd0;
                    hold       = 1'b1;
                    pc_wr      = 1'b0;
                    ifid_wr    = 1'b0;
                end else if (load_use) begin
                    bubble  = 1'b1;
                    pc_wr   = 1'b0;
                    ifid_wr = 1'b0;
                    if (LU_BUBBLES > 1) begin
                        state_next = LU_STALL;
                        bub_next   = LU_INIT;
                    end
                end else if (br_dep) begin
                    bubble  = 1'b1;
                    pc_wr   = 1'b0;
                    ifid_wr = 1'b0;
                end else if (hz.ID_br_ctrl) begin
                    flush = 1'b1;
                end
            end
            LU_STALL: begin
                pc_wr   = 1'b0;
                ifid_wr = 1'b0;
                if (mem_stall) begin
                    // Remaining bubbles are kept in bub_reg across the wait.
                    state_next = MEM_WAIT;
                    timer_next = 8'd0;
                    hold       = 1'b1;
                end else begin
                    bubble = 1'b1;
                    if (bub_reg <= 2'd1) begin
                        state_next = RUN;
                        bub_next   = 2'd0;
                    end else begin
                        bub_next = bub_reg - 2'd1;
                    end
                end
            end
            MEM_WAIT: begin
                pc_wr   = 1'b0;
                ifid_wr = 1'b0;
                if (hz.dmem_ack) begin
                    state_next = (bub_reg != 2'd0) ? LU_STALL : RUN;
                end else begin
                    hold = 1'b1;
                    if (timer_reg == TIMER_LAST) begin
                        mem_err_next = 1'b1;
                        drop_next    = 1'b1;
                        bub_next     = 2'd0;
                        state_next   = RUN;
                    end else begin
                        timer_next = timer_reg + 8'd1;
                    end
                end
            end
            default: begin
                state_next = RUN;
                bub_next   = 2'd0;
            end
        endcase
        // Reset values must show on the outputs while reset is held, not only after an edge.
        if (reset) begin
            pc_wr   = 1'b1;
            ifid_wr = 1'b1;
            flush   = 1'b0;
            bubble  = 1'b0;
            hold    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= RUN;
            bub_reg     <= 2'd0;
            timer_reg   <= 8'd0;
            mem_err_reg <= 1'b0;
            drop_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bub_reg     <= bub_next;
            timer_reg   <= timer_next;
            mem_err_reg <= mem_err_next;
            drop_reg    <= drop_next;
        end
    end

    assign hz.PC_wrEn      = pc_wr;
    assign hz.IF_ID_wrEn   = ifid_wr;
    assign hz.IF_flush     = flush;
    assign hz.ID_EX_bubble = bubble;
    assign hz.pipe_hold    = hold;
    assign hz.mem_err      = mem_err_reg;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_reg, flush_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= 16'd0;
            flush_cnt_reg <= 16'd0;
        end else begin
            if (!pc_wr && stall_cnt_reg != 16'hFFFF)
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            if (flush && flush_cnt_reg != 16'hFFFF)
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
        end
    end

    assign hz.stall_cnt = stall_cnt_reg;
    assign hz.flush_cnt = flush_cnt_reg;
`else
    assign hz.stall_cnt = 16'd0;
    assign hz.flush_cnt = 16'd0;
`endif
endmodule
